// File: rtl/ex_muldiv_unit.sv
// Iterative RV64M multiply/divide unit for the EX stage: radix-2 shift-add multiply, restoring divide.
// Define MULDIV_FAST_MUL_EN to compute multiplies in one cycle with a combinational product.
module ex_muldiv_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [4:0]      rd_in,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);
  localparam int W2 = 2 * XLEN;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic            word_q, word_d;
  logic [4:0]      rd_lat_q, rd_lat_d;
  logic [4:0]      rd_out_q, rd_out_d;
  logic            neg_q, neg_d;
  logic            rneg_q, rneg_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [W2-1:0]   acc_q, acc_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] result_q, result_d;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    return {{(XLEN-32){v[31]}}, v[31:0]};
  endfunction

  // prod is the true (unshifted) magnitude product of the two operands
  function automatic logic [XLEN-1:0] mul_pick(input logic [W2-1:0] prod, input logic neg,
                                               input logic [2:0] fop, input logic fword);
    logic [W2-1:0] p;
    p = neg ? -prod : prod;
    if (fop == 3'd0) return fword ? sext32(p[XLEN-1:0]) : p[XLEN-1:0];
    return p[W2-1:XLEN];
  endfunction

  // acc holds {remainder, quotient} magnitudes
  function automatic logic [XLEN-1:0] div_pick(input logic [W2-1:0] acc, input logic qneg,
                                               input logic rneg, input logic [2:0] fop,
                                               input logic fword);
    logic [XLEN-1:0] q, r, v;
    q = acc[XLEN-1:0];
    r = acc[W2-1:XLEN];
    v = fop[1] ? (rneg ? -r : r) : (qneg ? -q : q);
    return fword ? sext32(v) : v;
  endfunction

  logic            sgn1, sgn2, a_neg, b_neg, div0, ovf;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val, dvd_res, special_res;
  logic [5:0]      cnt_init;
  logic [XLEN:0]   mul_sum, div_rs, div_diff;
  logic            div_ge;
  logic [W2-1:0]   mul_acc, div_acc, mul_prod;

  always_comb begin
    sgn1  = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    sgn2  = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    a_ext = word ? (sgn1 ? sext32(src1) : {{(XLEN-32){1'b0}}, src1[31:0]}) : src1;
    b_ext = word ? (sgn2 ? sext32(src2) : {{(XLEN-32){1'b0}}, src2[31:0]}) : src2;
    a_neg = sgn1 & a_ext[XLEN-1];
    b_neg = sgn2 & b_ext[XLEN-1];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;
    min_val = word ? {{(XLEN-31){1'b1}}, 31'd0} : {1'b1, {(XLEN-1){1'b0}}};
    div0  = op[2] && (b_ext == '0);
    ovf   = op[2] && !op[0] && (a_ext == min_val) && (b_ext == '1);
    dvd_res = word ? sext32(src1) : src1;
    if (div0) special_res = op[1] ? dvd_res : '1;
    else      special_res = op[1] ? '0 : dvd_res;
    cnt_init = word ? 6'd31 : 6'd63;

    mul_sum  = {1'b0, acc_q[W2-1:XLEN]} + {1'b0, (acc_q[0] ? mcand_q : '0)};
    mul_acc  = {mul_sum, acc_q[XLEN-1:1]};
    // Word multiplies stop after 32 shifts, so the product sits 32 bits higher
    mul_prod = word_q ? (mul_acc >> 32) : mul_acc;
    div_rs   = {acc_q[W2-1:XLEN], acc_q[XLEN-1]};
    div_ge   = div_rs >= {1'b0, mcand_q};
    div_diff = div_rs - {1'b0, mcand_q};
    div_acc  = {(div_ge ? div_diff[XLEN-1:0] : div_rs[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    word_d   = word_q;
    rd_lat_d = rd_lat_q;
    rd_out_d = rd_out_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    result_d = result_q;
    stall    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          stall    = 1'b1;
          op_d     = op;
          word_d   = word;
          rd_lat_d = rd_in;
          neg_d    = a_neg ^ b_neg;
          rneg_d   = a_neg;
          cnt_d    = cnt_init;
          if (op[2]) begin
            if (div0 || ovf) begin
              result_d = special_res;
              rd_out_d = rd_in;
              state_d  = S_DONE;
            end else begin
              mcand_d = b_mag;
              // Word dividends are pre-shifted so 32 iterations consume them fully
              acc_d   = {{XLEN{1'b0}}, (word ? (a_mag << 32) : a_mag)};
              state_d = S_DIV;
            end
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            result_d = mul_pick({{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag},
                                a_neg ^ b_neg, op, word);
            rd_out_d = rd_in;
            state_d  = S_DONE;
`else
            mcand_d = a_mag;
            acc_d   = {{XLEN{1'b0}}, b_mag};
            state_d = S_MUL;
`endif
          end
        end
      end
      S_MUL, S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          stall = 1'b1;
          acc_d = (state_q == S_MUL) ? mul_acc : div_acc;
          if (cnt_q == 6'd0) begin
            result_d = (state_q == S_MUL) ? mul_pick(mul_prod, neg_q, op_q, word_q)
                                          : div_pick(div_acc, neg_q, rneg_q, op_q, word_q);
            rd_out_d = rd_lat_q;
            state_d  = S_DONE;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      word_q   <= 1'b0;
      rd_lat_q <= '0;
      rd_out_q <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      word_q   <= word_d;
      rd_lat_q <= rd_lat_d;
      rd_out_q <= rd_out_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == S_MUL) || (state_q == S_DIV);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign rd_out = rd_out_q;
endmodule
